// File: rtl/coord_accum_reg_pkg.sv
// Shared definitions for the coordinate accumulator slice.
//   state_e : scan state (IDLE / RUN / DONE)
//   DEF_W   : default coordinate width
package coord_accum_reg_pkg;

    localparam int DEF_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/coord_accum_reg_if.sv
// Command/result bundle of the coordinate accumulator.
//   master : drives CLEAR/LOAD/STEP commands, operands and limits; observes results
//   slave  : the accumulator side
interface coord_accum_reg_if
    import coord_accum_reg_pkg::*;
#(
    parameter int W = DEF_W
);
    logic                CLEAR;
    logic                LOAD_EN;
    logic signed [W-1:0] LOAD_X;
    logic signed [W-1:0] LOAD_Y;
    logic                STEP_EN;
    logic signed [W-1:0] STEP_X;
    logic signed [W-1:0] STEP_Y;
    logic signed [W-1:0] LIMIT_X;
    logic signed [W-1:0] LIMIT_Y;
    logic                SAT_MODE;
    logic signed [W-1:0] X_OUT;
    logic signed [W-1:0] Y_OUT;
    logic                BUSY;
    logic                ROW_END;
    logic                FRAME_END;
    logic                OVF;

    modport master (
        output CLEAR, LOAD_EN, LOAD_X, LOAD_Y, STEP_EN, STEP_X, STEP_Y,
               LIMIT_X, LIMIT_Y, SAT_MODE,
        input  X_OUT, Y_OUT, BUSY, ROW_END, FRAME_END, OVF
    );

    modport slave (
        input  CLEAR, LOAD_EN, LOAD_X, LOAD_Y, STEP_EN, STEP_X, STEP_Y,
               LIMIT_X, LIMIT_Y, SAT_MODE,
        output X_OUT, Y_OUT, BUSY, ROW_END, FRAME_END, OVF
    );
endinterface

// File: rtl/coord_accum_reg_sat_add.sv
// sat_add: W-bit signed adder with overflow detect and saturate/wrap select.
//   a_i, b_i    : signed operands
//   sat_mode_i  : 1 = clamp to max/min on overflow, 0 = keep low W bits
//   sum_o       : result
//   ovf_o       : exact sum does not fit in W bits
module coord_accum_reg_sat_add
    import coord_accum_reg_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] b_i,
    input  logic                sat_mode_i,
    output logic signed [W-1:0] sum_o,
    output logic                ovf_o
);
    logic signed [W:0] sum_full;

    assign sum_full = {a_i[W-1], a_i} + {b_i[W-1], b_i};
    // Top two bits disagree exactly when the sum left the W-bit range.
    assign ovf_o    = sum_full[W] ^ sum_full[W-1];

    always_comb begin
        sum_o = sum_full[W-1:0];
        if (ovf_o && sat_mode_i) begin
            // sign of the exact sum picks the rail
            sum_o = sum_full[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end
endmodule

// File: rtl/coord_accum_reg.sv
// Raster coordinate accumulator: X advances by STEP_X per accepted step,
// wraps to its base when it passes LIMIT_X while Y advances by STEP_Y,
// and the scan finishes when Y would pass LIMIT_Y.
//   CLK, RST_ASYNC_N : clock, async active-low reset
//   bus (slave)      : commands, operands, limits, registered results
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | no scan loaded, steps ignored
// ST_RUN  | scan active, steps accepted, BUSY high
// ST_DONE | scan finished, outputs frozen until LOAD/CLEAR
module coord_accum_reg
    import coord_accum_reg_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic               CLK,
    input  logic               RST_ASYNC_N,
    coord_accum_reg_if.slave   bus
);
    state_e              state_q, state_d;
    logic signed [W-1:0] x_q, x_d;
    logic signed [W-1:0] y_q, y_d;
    logic signed [W-1:0] x_base_q, x_base_d;
    logic                ovf_q, ovf_d;
    logic                row_end_q, row_end_d;
    logic                frame_end_q, frame_end_d;

    logic signed [W-1:0] cand_x, cand_y;
    logic                ovf_x, ovf_y;

    coord_accum_reg_sat_add #(.W(W)) u_add_x (
        .a_i        (x_q),
        .b_i        (bus.STEP_X),
        .sat_mode_i (bus.SAT_MODE),
        .sum_o      (cand_x),
        .ovf_o      (ovf_x)
    );

    coord_accum_reg_sat_add #(.W(W)) u_add_y (
        .a_i        (y_q),
        .b_i        (bus.STEP_Y),
        .sat_mode_i (bus.SAT_MODE),
        .sum_o      (cand_y),
        .ovf_o      (ovf_y)
    );

    always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
        if (!RST_ASYNC_N) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            x_base_q    <= '0;
            ovf_q       <= 1'b0;
            row_end_q   <= 1'b0;
            frame_end_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            x_base_q    <= x_base_d;
            ovf_q       <= ovf_d;
            row_end_q   <= row_end_d;
            frame_end_q <= frame_end_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        x_base_d    = x_base_q;
        ovf_d       = ovf_q;
        row_end_d   = 1'b0;
        frame_end_d = 1'b0;

        if (bus.CLEAR) begin
            state_d  = ST_IDLE;
            x_d      = '0;
            y_d      = '0;
            x_base_d = '0;
            ovf_d    = 1'b0;
        end else if (bus.LOAD_EN) begin
            state_d  = ST_RUN;
            x_d      = bus.LOAD_X;
            y_d      = bus.LOAD_Y;
            x_base_d = bus.LOAD_X;
            ovf_d    = 1'b0;
        end else if (bus.STEP_EN && state_q == ST_RUN) begin
            ovf_d = ovf_q | ovf_x;
            if (cand_x <= bus.LIMIT_X) begin
                x_d = cand_x;
            end else begin
                // Row wrap: Y is only advanced (and can only overflow) here.
                x_d       = x_base_q;
                row_end_d = 1'b1;
                ovf_d     = ovf_q | ovf_x | ovf_y;
                if (cand_y > bus.LIMIT_Y) begin
                    frame_end_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    y_d = cand_y;
                end
            end
        end
    end

    assign bus.X_OUT     = x_q;
    assign bus.Y_OUT     = y_q;
    assign bus.BUSY      = (state_q == ST_RUN);
    assign bus.ROW_END   = row_end_q;
    assign bus.FRAME_END = frame_end_q;
    assign bus.OVF       = ovf_q;
endmodule

// File: doc/coord_accum_reg.md
COORD_ACCUM_REG -- requirements
Module: coord_accum_reg

Interface
REQ-001 Parameter W, default 8: width of the signed two's-complement coordinates and steps.
REQ-002 CLK  input  1  clock; all state updates on the rising edge.
REQ-003 RST_ASYNC_N  input  1  reset, asynchronous, active-low.
REQ-004 CLEAR  input  1  synchronous clear to the reset state.
REQ-005 LOAD_EN  input  1  load base coordinates and start a scan.
REQ-006 LOAD_X, LOAD_Y  input  W each  signed base coordinates.
REQ-007 STEP_EN  input  1  request one accumulation step.
REQ-008 STEP_X, STEP_Y  input  W each  signed increments; sampled on each accepted step.
REQ-009 LIMIT_X, LIMIT_Y  input  W each  signed inclusive upper bounds; sampled on each accepted step.
REQ-010 SAT_MODE  input  1  1 = saturate on overflow, 0 = two's-complement wrap.
REQ-011 X_OUT, Y_OUT  output  W each  signed accumulated coordinates, registered.
REQ-012 BUSY  output  1  high while in RUN.
REQ-013 ROW_END  output  1  one-cycle pulse on X wrap to base.
REQ-014 FRAME_END  output  1  one-cycle pulse on scan completion.
REQ-015 OVF  output  1  sticky overflow flag.

Function
REQ-016 States: IDLE, RUN, DONE; registered outputs; 1-cycle latency from accepted command to output update.
REQ-017 Priority per cycle: CLEAR > LOAD_EN > STEP_EN.
REQ-018 CLEAR: reset state (REQ-027) in the next cycle, from any state.
REQ-019 LOAD_EN, any state: X_OUT <= LOAD_X, Y_OUT <= LOAD_Y; internal X_BASE <= LOAD_X; OVF <= 0; state <= RUN.
REQ-020 STEP_EN is accepted only in RUN; ignored in IDLE/DONE with no output change.
REQ-021 Accepted step: candidate X = X_OUT + STEP_X at W+1 bits; out of W-bit range -> OVF <= 1 and candidate becomes max/min (SAT_MODE=1) or low W bits (SAT_MODE=0).
REQ-022 Candidate X <= LIMIT_X (signed): X_OUT <= candidate X; Y_OUT unchanged; no pulse.
REQ-023 Candidate X > LIMIT_X: X_OUT <= X_BASE; candidate Y = Y_OUT + STEP_Y formed under REQ-021 rules; ROW_END pulses.
REQ-024 Additionally, candidate Y > LIMIT_Y: Y_OUT holds; FRAME_END pulses together with ROW_END; state <= DONE.
REQ-025 Otherwise, on row wrap, Y_OUT <= candidate Y; stay in RUN.
REQ-026 DONE holds outputs until LOAD_EN or CLEAR; OVF is cleared only by LOAD_EN, CLEAR or reset.

Reset
REQ-027 RST_ASYNC_N low, immediately and independent of CLK: X_OUT=0, Y_OUT=0, X_BASE=0, OVF=0, ROW_END=0, FRAME_END=0, BUSY=0, state IDLE.
REQ-028 Reset mid-scan discards all progress; a new LOAD_EN is required to resume.

Structure
REQ-029 Shared package holds the state enumeration (IDLE/RUN/DONE) and the default W.
REQ-030 One sub-module, sat_add: W-bit signed adder with W+1-bit sum, mode select, saturated/wrapped result and overflow flag, instantiated twice (X, Y).

Verification
REQ-031 W=8; LOAD 0,0; STEP_X=4, LIMIT_X=8, STEP_Y=1, LIMIT_Y=1; 6 steps -> X: 4,8,0,4,8,0; Y: 0,0,1,1,1,1; ROW_END on steps 3,6; FRAME_END and DONE on step 6.
REQ-032 RUN, X=120, STEP_X=10, LIMIT_X=127, SAT_MODE=1 -> X=127, OVF=1, no ROW_END; same with SAT_MODE=0 -> X=-126, OVF=1.
REQ-033 CLEAR, LOAD_EN and STEP_EN in the same cycle -> reset state, BUSY=0; LOAD_EN with STEP_EN -> load values only.
REQ-034 STEP_EN in IDLE and in DONE -> outputs unchanged, no pulses.
REQ-035 RST_ASYNC_N low between clock edges mid-scan -> outputs 0 immediately; subsequent STEP_EN ignored until LOAD_EN.
